pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_cmp.sv | 20 ++
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The state encoding is visible on the state port, so values are fixed.
package pipe_ctrl_pkg;

    localparam int REG_AW  = 5;
    localparam int STATE_W = 2;
    localparam int BUB_W   = 2;
    localparam int PERF_W  = 32;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic mem_wb_en;
        logic mem_wb_flush;
    } ctl_t;

    // Free-running pipeline: everything advances, nothing is squashed.
    function automatic ctl_t ctl_default();
        ctl_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
              id_ex_en: 1'b1, id_ex_flush: 1'b0,
              ex_mem_en: 1'b1, ex_mem_flush: 1'b0,
              mem_wb_en: 1'b1, mem_wb_flush: 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register controls between datapath and controller.
// slave = controller side, master = datapath side.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; ();

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_memread;
    logic              ex_modify_pc;
    logic              dmem_req;
    logic              dmem_ready;

    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
    logic mem_wb_flush;

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_memread, ex_modify_pc,
        input  dmem_req, dmem_ready,
        output pc_en, if_id_en, if_id_flush,
        output id_ex_en, id_ex_flush,
        output ex_mem_en, ex_mem_flush,
        output mem_wb_en, mem_wb_flush
    );

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_memread, ex_modify_pc,
        output dmem_req, dmem_ready,
        input  pc_en, if_id_en, if_id_flush,
        input  id_ex_en, id_ex_flush,
        input  ex_mem_en, ex_mem_flush,
        input  mem_wb_en, mem_wb_flush
    );

endinterface

// File: rtl/pipe_hazard_cmp.sv
// Load-use detector: a load in EX whose rd feeds a live source in ID.
// x0 never creates a dependency.
module pipe_hazard_cmp import pipe_ctrl_pkg::*; (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    output logic              hit
);

    logic m1;
    logic m2;

    assign m1  = uses_rs1 && (rs1 == ex_rd);
    assign m2  = uses_rs2 && (rs2 == ex_rd);
    assign hit = ex_memread && (ex_rd != '0) && (m1 || m2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory wait > redirect > load-use.
// Define PIPE_CTRL_PERF_EN to add stall_cycles / flush_events counters.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    pipe_ctrl_if.slave         bus,
    output logic [STATE_W-1:0] state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]  stall_cycles,
    output logic [PERF_W-1:0]  flush_events
`endif
);

    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(REDIRECT_BUBBLES);

    state_t           state_q;
    state_t           state_d;
    logic [BUB_W-1:0] bub_q;
    logic [BUB_W-1:0] bub_d;
    ctl_t             ctl;
    logic             lu_hit;
    logic             mem_wait;
    logic             redirect;

    pipe_hazard_cmp u_cmp (
        .rs1        (bus.id_rs1),
        .rs2        (bus.id_rs2),
        .uses_rs1   (bus.id_uses_rs1),
        .uses_rs2   (bus.id_uses_rs2),
        .ex_rd      (bus.ex_rd),
        .ex_memread (bus.ex_memread),
        .hit        (lu_hit)
    );

    // Once parked in MEM_WAIT, only dmem_ready releases the stall.
    assign mem_wait = !bus.dmem_ready
                   && (bus.dmem_req || state_q == MEM_WAIT);
    assign redirect = bus.ex_modify_pc && !mem_wait;

    // Control decode and next-state selection in priority order.
    always_comb begin
        ctl     = ctl_default();
        state_d = state_q;
        bub_d   = bub_q;
        if (rst) begin
            state_d = RUN;
            bub_d   = '0;
        end else if (mem_wait) begin
            // mem_wb flush dominates its enable inside the register.
            ctl              = '0;
            ctl.mem_wb_flush = 1'b1;
            state_d          = MEM_WAIT;
        end else if (redirect) begin
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
            bub_d           = BUB_LOAD;
            state_d         = REDIRECT;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (lu_hit) begin
                        ctl.pc_en       = 1'b0;
                        ctl.if_id_en    = 1'b0;
                        ctl.id_ex_flush = 1'b1;
                        state_d         = LD_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                LD_STALL: state_d = RUN;
                MEM_WAIT: state_d = RUN;
                REDIRECT: begin
                    ctl.if_id_flush = 1'b1;
                    bub_d   = (bub_q == '0) ? '0 : bub_q - 1'b1;
                    state_d = (bub_q <= 1) ? RUN : REDIRECT;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // FSM state and redirect bubble counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    assign state            = state_q;
    assign bus.pc_en        = ctl.pc_en;
    assign bus.if_id_en     = ctl.if_id_en;
    assign bus.if_id_flush  = ctl.if_id_flush;
    assign bus.id_ex_en     = ctl.id_ex_en;
    assign bus.id_ex_flush  = ctl.id_ex_flush;
    assign bus.ex_mem_en    = ctl.ex_mem_en;
    assign bus.ex_mem_flush = ctl.ex_mem_flush;
    assign bus.mem_wb_en    = ctl.mem_wb_en;
    assign bus.mem_wb_flush = ctl.mem_wb_flush;

`ifdef PIPE_CTRL_PERF_EN
    // Stall cycles and accepted redirects; both wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!ctl.pc_en)
                stall_cycles <= stall_cycles + 1'b1;
            if (redirect)
                flush_events <= flush_events + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level rule model queues expected
// controls; a negedge monitor pops and compares against the DUT.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int BUB = 2;

    // {pc,if_id en/fl,id_ex en/fl,ex_mem en/fl,mem_wb en/fl}
    localparam logic [8:0] C_DEF = 9'b1_10_10_10_10;
    localparam logic [8:0] C_MW  = 9'b0_00_00_00_01;
    localparam logic [8:0] C_RD  = 9'b1_11_11_10_10;
    localparam logic [8:0] C_LU  = 9'b0_00_11_10_10;
    localparam logic [8:0] C_RB  = 9'b1_11_10_10_10;

    typedef struct {
        logic [8:0] ctl;
        int         st;
        longint     stalls;
        longint     flushes;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [STATE_W-1:0] state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    pipe_ctrl_if bus ();

    pipe_ctrl #(.REDIRECT_BUBBLES(BUB)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .state (state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    always #5 clk = ~clk;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Model: mode in spec numbering, flushes still owed, event counts.
    int     m_mode = 0;
    int     m_left = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    task automatic chk(input string name, input string tag,
                       input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s [%s]: got %0h want %0h", name, tag, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] got;
            e = q.pop_front();
            got = {bus.pc_en, bus.if_id_en, bus.if_id_flush,
                   bus.id_ex_en, bus.id_ex_flush,
                   bus.ex_mem_en, bus.ex_mem_flush,
                   bus.mem_wb_en, bus.mem_wb_flush};
            chk("ctl", e.tag, longint'(got), longint'(e.ctl));
            chk("state", e.tag, longint'(state), longint'(e.st));
`ifdef PIPE_CTRL_PERF_EN
            chk("stall_cycles", e.tag, longint'(stall_cycles), e.stalls);
            chk("flush_events", e.tag, longint'(flush_events), e.flushes);
`endif
        end
    end

    // Apply current inputs to the rule model, queue the expectation,
    // then advance one clock.
    task automatic step(input string tag);
        exp_t   e;
        logic   hz;
        logic   w;
        logic   r;
        logic   lu;
        logic [8:0] c;
        int     nm;
        e.tag = tag;
        if (rst) begin
            m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
            e.ctl = C_DEF; e.st = 0; e.stalls = 0; e.flushes = 0;
        end else begin
            hz = (bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd)
              || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd);
            w  = !bus.dmem_ready && (bus.dmem_req || m_mode == 2);
            r  = bus.ex_modify_pc && !w;
            lu = (m_mode == 0) && bus.ex_memread && bus.ex_rd != 0 && hz;
            e.st = m_mode; e.stalls = m_stall; e.flushes = m_flush;
            if (w) begin
                c = C_MW; nm = 2;
            end else if (r) begin
                c = C_RD; nm = 3; m_left = BUB; m_flush++;
            end else if (lu) begin
                c = C_LU; nm = 1;
            end else if (m_mode == 3 && m_left > 0) begin
                c = C_RB; m_left--; nm = (m_left == 0) ? 0 : 3;
            end else begin
                c = C_DEF; nm = 0;
            end
            if (!c[8]) m_stall++;
            m_mode = nm;
            e.ctl = c;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_rd = '0; bus.ex_memread = 1'b0; bus.ex_modify_pc = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        // Reset held with a live load-use pattern: defaults expected.
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
        step("rst_hold");
        step("rst_hold2");
        rst = 1'b0;
        idle();
        step("post_rst");

        // Load-use on rs1.
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
        step("lu");
        idle();
        step("lu_stall");
        step("lu_done");

        // Load to x0 never stalls.
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd0;
        bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
        step("lu_x0");
        idle();
        step("lu_x0_after");

        // Redirect pulse.
        bus.ex_modify_pc = 1'b1;
        step("redir");
        idle();
        for (int i = 0; i < 3; i++) step("redir_tail");

        // Memory wait for four cycles.
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("mw");
        bus.dmem_ready = 1'b1;
        step("mw_ready");
        idle();
        step("mw_after");

        // Load-use and redirect together: redirect wins.
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd7;
        bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
        bus.ex_modify_pc = 1'b1;
        step("lu_redir");
        idle();
        for (int i = 0; i < 3; i++) step("lu_redir_tail");

        // Memory wait with redirect held: redirect on ready cycle.
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        bus.ex_modify_pc = 1'b1;
        step("mw_redir");
        step("mw_redir2");
        bus.dmem_ready = 1'b1;
        step("mw_redir_ready");
        idle();
        for (int i = 0; i < 3; i++) step("mw_redir_tail");

        // Reset in the second MEM_WAIT cycle.
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        step("mw_pre");
        step("mw_1st");
        rst = 1'b1;
        step("mw_rst");
        rst = 1'b0;
        idle();
        step("rst_rel");
        step("rst_rel2");

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.id_rs1 = 5'($urandom_range(0, 7));
            bus.id_rs2 = 5'($urandom_range(0, 7));
            bus.id_uses_rs1 = 1'($urandom_range(0, 1));
            bus.id_uses_rs2 = 1'($urandom_range(0, 1));
            bus.ex_rd = 5'($urandom_range(0, 7));
            bus.ex_memread = ($urandom_range(0, 2) == 0);
            bus.ex_modify_pc = ($urandom_range(0, 7) == 0);
            bus.dmem_req = ($urandom_range(0, 5) == 0) || (m_mode == 2);
            bus.dmem_ready = ($urandom_range(0, 1) == 0);
            step("rand");
        end
        rst = 1'b0;
        idle();
        step("drain");
        step("drain2");

        @(negedge clk);
        #1;
        chk("queue_empty", "end", longint'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
